time_keeper: RTL and testbench

Digital-clock timekeeping core. It consumes a one-cycle 1 Hz enable pulse generated in the `clk_100Mhz` domain and maintains hours, minutes and seconds as packed BCD. It also provides a three-state run/set-hour/set-minute control for the two board keys. Its outputs feed the 7-segment scan logic directly, and it raises a one-cycle hourly chime pulse.

---
 rtl/time_keeper.sv | 141 ++++++++++++++
 tb/tb_time_keeper.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/time_keeper.sv
// Digital-clock timekeeping core: packed-BCD hours/minutes/seconds driven by a 1 Hz
// enable, with a RUN / SET_HOUR / SET_MIN control for two keys and an hourly chime.
module time_keeper #(
  parameter bit HOUR24 = 1'b1
) (
  input  logic       clk_100Mhz,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       key_mode,
  input  logic       key_inc,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] state,
  output logic       chime
);

  // Input semantics: tick_1hz, key_mode and key_inc are qualifiers with no
  // handshake; every cycle one of them is high counts as one event, and all
  // outputs are registered and valid on every cycle out of reset.

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2
  } tk_state_e;

  localparam logic [7:0] HOUR_RESET = HOUR24 ? 8'h00 : 8'h12;

  tk_state_e  state_q, state_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic [7:0] sec_q, sec_d;
  logic       chime_q, chime_d;

  // Increment a packed BCD pair that counts 00..59.
  function automatic logic [7:0] inc_sixty(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h59) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  // Hours wrap 23->00 in 24-hour mode and 12->01 in 12-hour mode.
  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    logic [7:0] r;
    if (HOUR24 && (v == 8'h23)) begin
      r = 8'h00;
    end else if (!HOUR24 && (v == 8'h12)) begin
      r = 8'h01;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      hour_q  <= HOUR_RESET;
      min_q   <= 8'h00;
      sec_q   <= 8'h00;
      chime_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      chime_q <= chime_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    chime_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (tick_1hz) begin
          if (sec_q == 8'h59) begin
            sec_d = 8'h00;
            if (min_q == 8'h59) begin
              min_d   = 8'h00;
              hour_d  = inc_hour(hour_q);
              chime_d = 1'b1;
            end else begin
              min_d = inc_sixty(min_q);
            end
          end else begin
            sec_d = inc_sixty(sec_q);
          end
        end
        // The tick's carry is kept; only the seconds are discarded on entry to set.
        if (key_mode) begin
          state_d = SET_HOUR;
          sec_d   = 8'h00;
        end
      end

      SET_HOUR: begin
        sec_d = 8'h00;
        if (key_mode) begin
          state_d = SET_MIN;
        end else if (key_inc) begin
          hour_d = inc_hour(hour_q);
        end
      end

      SET_MIN: begin
        sec_d = 8'h00;
        if (key_mode) begin
          state_d = RUN;
        end else if (key_inc) begin
          min_d = inc_sixty(min_q);
        end
      end

      default: begin
        state_d = RUN;
        sec_d   = 8'h00;
      end
    endcase
  end

  assign hour_bcd = hour_q;
  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign state    = state_q;
  assign chime    = chime_q;

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: 24-hour and 12-hour instances side by side, driven with
// directed and random pulses and checked against an integer time model.
module tb_time_keeper;

  localparam int W = 27;

  logic clk_100Mhz = 1'b0;
  logic rst_n      = 1'b0;
  logic tick_1hz   = 1'b0;
  logic key_mode   = 1'b0;
  logic key_inc    = 1'b0;

  logic [7:0] h24_hour, h24_min, h24_sec;
  logic [1:0] h24_state;
  logic       h24_chime;
  logic [7:0] h12_hour, h12_min, h12_sec;
  logic [1:0] h12_state;
  logic       h12_chime;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q24[$];
  logic [W-1:0] exp_q12[$];

  // index 1 = 24-hour model, index 0 = 12-hour model
  int mh[2];
  int mm[2];
  int ms[2];
  int mst[2];
  bit mch[2];

  time_keeper #(.HOUR24(1'b1)) dut24 (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .key_mode(key_mode), .key_inc(key_inc),
    .hour_bcd(h24_hour), .min_bcd(h24_min), .sec_bcd(h24_sec),
    .state(h24_state), .chime(h24_chime)
  );

  time_keeper #(.HOUR24(1'b0)) dut12 (
    .clk_100Mhz(clk_100Mhz), .rst_n(rst_n), .tick_1hz(tick_1hz),
    .key_mode(key_mode), .key_inc(key_inc),
    .hour_bcd(h12_hour), .min_bcd(h12_min), .sec_bcd(h12_sec),
    .state(h12_state), .chime(h12_chime)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int next_hour(input int i, input int h);
    return (i == 1) ? (h + 1) % 24 : (h % 12) + 1;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mh[i]  = (i == 1) ? 0 : 12;
      mm[i]  = 0;
      ms[i]  = 0;
      mst[i] = 0;
      mch[i] = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit t, input bit md, input bit in);
    for (int i = 0; i < 2; i++) begin
      mch[i] = 1'b0;
      if (mst[i] == 0) begin
        if (t) begin
          ms[i]++;
          if (ms[i] == 60) begin
            ms[i] = 0;
            mm[i]++;
            if (mm[i] == 60) begin
              mm[i]  = 0;
              mh[i]  = next_hour(i, mh[i]);
              mch[i] = 1'b1;
            end
          end
        end
        if (md) begin
          ms[i]  = 0;
          mst[i] = 1;
        end
      end else if (mst[i] == 1) begin
        if (md) mst[i] = 2;
        else if (in) mh[i] = next_hour(i, mh[i]);
      end else begin
        if (md) mst[i] = 0;
        else if (in) mm[i] = (mm[i] + 1) % 60;
      end
    end
  endfunction

  function automatic logic [W-1:0] expect_word(input int i);
    return {2'(mst[i]), to_bcd(mh[i]), to_bcd(mm[i]), to_bcd(ms[i]), mch[i]};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d %h:%h:%h chime=%b, expected st=%0d %h:%h:%h chime=%b",
               name, act[26:25], act[24:17], act[16:9], act[8:1], act[0],
               exp[26:25], exp[24:17], exp[16:9], exp[8:1], exp[0]);
    end
  endtask

  // Monitor: outputs are valid every cycle, so each queued expectation is
  // matched against the registered outputs just after the following edge.
  initial begin
    forever begin
      @(posedge clk_100Mhz);
      #1;
      if (exp_q24.size() > 0)
        check("dut24", {h24_state, h24_hour, h24_min, h24_sec, h24_chime}, exp_q24.pop_front());
      if (exp_q12.size() > 0)
        check("dut12", {h12_state, h12_hour, h12_min, h12_sec, h12_chime}, exp_q12.pop_front());
    end
  end

  task automatic step(input bit t, input bit md, input bit in);
    @(negedge clk_100Mhz);
    tick_1hz = t;
    key_mode = md;
    key_inc  = in;
    model_step(t, md, in);
    exp_q24.push_back(expect_word(1));
    exp_q12.push_back(expect_word(0));
  endtask

  task automatic do_reset();
    @(negedge clk_100Mhz);
    rst_n    = 1'b0;
    tick_1hz = 1'b0;
    key_mode = 1'b0;
    key_inc  = 1'b0;
    model_reset();
    exp_q24.delete();
    exp_q12.delete();
    #1;
    check("reset24", {h24_state, h24_hour, h24_min, h24_sec, h24_chime}, expect_word(1));
    check("reset12", {h12_state, h12_hour, h12_min, h12_sec, h12_chime}, expect_word(0));
    repeat (2) @(negedge clk_100Mhz);
    rst_n = 1'b1;
  endtask

  // Steer the selected model to h:m:s through the set states, ending in RUN.
  task automatic set_time(input int sel, input int h, input int m, input int s);
    int n;
    while (mst[sel] != 0) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n = 0;
    while (mh[sel] != h && n < 30) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    step(1'b0, 1'b1, 1'b0);
    n = 0;
    while (mm[sel] != m && n < 70) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    step(1'b0, 1'b1, 1'b0);
    repeat (s) step(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    do_reset();

    // first ticks out of reset
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // 24-hour full rollover with chime
    set_time(1, 23, 59, 58);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // 12-hour rollover, then manual 12 -> 01 in SET_HOUR
    set_time(0, 12, 59, 59);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int n = 0; n < 12 && mh[0] != 12; n++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // set sequence from 10:20:37 with ticks arriving during set
    set_time(1, 10, 20, 37);
    step(1'b0, 1'b1, 1'b0);
    repeat (15) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    repeat (45) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // simultaneous tick + mode on an hour rollover, then mode + inc in SET_MIN
    set_time(1, 5, 59, 59);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);

    // reset while in SET_MIN at 14:33
    set_time(1, 14, 33, 0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b0, 1'b0);

    // random pulses, including wide pulses and occasional resets
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    // random run from just before an hour boundary in both modes
    set_time(1, 11, 59, 50);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 1) == 1, 1'b0, $urandom_range(0, 1) == 1);

    step(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk_100Mhz);
    checks++;
    if (exp_q24.size() != 0 || exp_q12.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", exp_q24.size(), exp_q12.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
